// File: rtl/pwm_clkgen.sv
// pwm_clkgen: NCH independent programmable clock / PWM generators.
//
// Each channel runs a small IDLE -> PHASE -> RUN state machine driven by its
// enable bit. The channel produces a registered waveform with period P and high
// time H, where P = max(period,1) and H = min(high,P). The first high cycle
// follows the enable edge after 'phase' cycles.
//
// Configuration writes use a valid/ready handshake. A write to an idle channel
// updates the active registers directly. A write to a running channel lands in
// a shadow set. The shadow is applied at the next period wrap, or when the
// channel is disabled.
//
// Optional feature: define PWM_CLKGEN_STROBE_EN to add rise_strb, a registered
// one-cycle strobe on the first cycle of every high interval of clk_out.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          per-channel run enable (level)
//   cfg_valid   configuration write request
//   cfg_ready   write accepted when high with cfg_valid (combinational)
//   cfg_ch      target channel of the write
//   cfg_period  period in cycles
//   cfg_high    high time in cycles
//   cfg_phase   delay from enable to first high cycle
//   clk_out     generated waveforms (registered)
//   rise_strb   rising-edge strobes (PWM_CLKGEN_STROBE_EN only)
module pwm_clkgen #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    input  logic [CW-1:0]  cfg_high,
    input  logic [CW-1:0]  cfg_phase,
    output logic [NCH-1:0] clk_out
`ifdef PWM_CLKGEN_STROBE_EN
    ,
    output logic [NCH-1:0] rise_strb
`endif
);

    typedef enum logic [1:0] {IDLE, PHASE, RUN} state_t;

    logic [NCH-1:0] pending;
    logic           ch_ok;
    logic           accept;

    // Channel numbers beyond NCH exist only when NCH is not a power of two.
    generate
        if ((1 << CHW) == NCH) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = ({1'b0, cfg_ch} < (CHW + 1)'(NCH));
        end
    endgenerate

    // Out-of-range writes are acknowledged and dropped.
    assign cfg_ready = rst | ~ch_ok | ~pending[cfg_ch];
    assign accept    = cfg_valid & ~rst & ch_ok & ~pending[cfg_ch];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t        state_reg, state_next;
            logic [CW-1:0] cnt_reg, cnt_next;
            logic [CW-1:0] per_reg, per_next;
            logic [CW-1:0] high_reg, high_next;
            logic [CW-1:0] phase_reg, phase_next;
            logic [CW-1:0] sh_per_reg, sh_per_next;
            logic [CW-1:0] sh_high_reg, sh_high_next;
            logic [CW-1:0] sh_phase_reg, sh_phase_next;
            logic          pend_reg, pend_next;
            logic          out_reg, out_next;
            logic          wr;
            logic [CW-1:0] p_eff;
            logic [CW-1:0] p_next_eff;
            logic [CW-1:0] h_next_eff;

            assign wr    = accept && (cfg_ch == CHW'(gi));
            assign p_eff = (per_reg == '0) ? CW'(1) : per_reg;

            always_comb begin
                state_next    = state_reg;
                cnt_next      = cnt_reg;
                per_next      = per_reg;
                high_next     = high_reg;
                phase_next    = phase_reg;
                sh_per_next   = sh_per_reg;
                sh_high_next  = sh_high_reg;
                sh_phase_next = sh_phase_reg;
                pend_next     = pend_reg;
                p_next_eff    = '0;
                h_next_eff    = '0;
                out_next      = 1'b0;

                if (!en[gi]) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    pend_next  = 1'b0;
                    // The channel is becoming idle, so a write landing on this
                    // edge goes straight to the active set.
                    if (wr) begin
                        per_next   = cfg_period;
                        high_next  = cfg_high;
                        phase_next = cfg_phase;
                    end else if (pend_reg) begin
                        per_next   = sh_per_reg;
                        high_next  = sh_high_reg;
                        phase_next = sh_phase_reg;
                    end
                end else begin
                    case (state_reg)
                        IDLE: begin
                            // Exit decision uses the phase held before this edge.
                            state_next = (phase_reg == '0) ? RUN : PHASE;
                            cnt_next   = '0;
                            if (wr) begin
                                per_next   = cfg_period;
                                high_next  = cfg_high;
                                phase_next = cfg_phase;
                            end
                        end
                        PHASE: begin
                            if (cnt_reg == phase_reg - CW'(1)) begin
                                state_next = RUN;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg + CW'(1);
                            end
                        end
                        default: begin
                            if (cnt_reg == p_eff - CW'(1)) begin
                                cnt_next = '0;
                                if (pend_reg) begin
                                    per_next   = sh_per_reg;
                                    high_next  = sh_high_reg;
                                    phase_next = sh_phase_reg;
                                    pend_next  = 1'b0;
                                end
                            end else begin
                                cnt_next = cnt_reg + CW'(1);
                            end
                        end
                    endcase
                    // A write to a running channel waits in the shadow. At a
                    // wrap it sets pending only after the old flag was consumed.
                    if (wr && state_reg != IDLE) begin
                        sh_per_next   = cfg_period;
                        sh_high_next  = cfg_high;
                        sh_phase_next = cfg_phase;
                        pend_next     = 1'b1;
                    end
                end

                // Output is computed from next state so that it lines up with
                // the counter value of the coming cycle.
                p_next_eff = (per_next == '0) ? CW'(1) : per_next;
                h_next_eff = (high_next > p_next_eff) ? p_next_eff : high_next;
                out_next   = (state_next == RUN) && (cnt_next < h_next_eff);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg    <= IDLE;
                    cnt_reg      <= '0;
                    per_reg      <= CW'(2);
                    high_reg     <= CW'(1);
                    phase_reg    <= '0;
                    sh_per_reg   <= '0;
                    sh_high_reg  <= '0;
                    sh_phase_reg <= '0;
                    pend_reg     <= 1'b0;
                    out_reg      <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    cnt_reg      <= cnt_next;
                    per_reg      <= per_next;
                    high_reg     <= high_next;
                    phase_reg    <= phase_next;
                    sh_per_reg   <= sh_per_next;
                    sh_high_reg  <= sh_high_next;
                    sh_phase_reg <= sh_phase_next;
                    pend_reg     <= pend_next;
                    out_reg      <= out_next;
                end
            end

            assign clk_out[gi] = out_reg;
            assign pending[gi] = pend_reg;

`ifdef PWM_CLKGEN_STROBE_EN
            logic strb_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    strb_reg <= 1'b0;
                end else begin
                    strb_reg <= out_next & ~out_reg;
                end
            end
            assign rise_strb[gi] = strb_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_pwm_clkgen.sv
// tb_pwm_clkgen: self-checking bench for pwm_clkgen (NCH=4, CW=16).
// Table-driven waveform vectors, hand sequences for pending/disable/reset
// corners, then randomized traffic. Every cycle is compared against a
// behavioural model that tracks elapsed time and position within the period.
module tb_pwm_clkgen;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_period, cfg_high, cfg_phase;
    logic [NCH-1:0] clk_out;
`ifdef PWM_CLKGEN_STROBE_EN
    logic [NCH-1:0] rise_strb;
`endif

    pwm_clkgen #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .clk_out(clk_out)
`ifdef PWM_CLKGEN_STROBE_EN
        , .rise_strb(rise_strb)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit last_ready;

    // Reference model state.
    int m_per[NCH], m_high[NCH], m_ph[NCH];
    int s_per[NCH], s_high[NCH], s_ph[NCH];
    bit m_pend[NCH], m_run[NCH], m_out[NCH], m_rise[NCH];
    int m_t[NCH], m_tph[NCH], m_pos[NCH];

    function automatic int p_of(int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic int h_of(int p, int h);
        return (h > p_of(p)) ? p_of(p) : h;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit acc;
        bit old;
        acc = cfg_valid && !rst && !m_pend[cfg_ch];
        for (int i = 0; i < NCH; i++) begin
            bit wr;
            wr  = acc && (int'(cfg_ch) == i);
            old = m_out[i];
            if (rst) begin
                m_per[i] = 2; m_high[i] = 1; m_ph[i] = 0;
                s_per[i] = 0; s_high[i] = 0; s_ph[i] = 0;
                m_pend[i] = 0; m_run[i] = 0; m_t[i] = 0; m_tph[i] = 0; m_pos[i] = 0;
                m_out[i] = 0; m_rise[i] = 0;
                continue;
            end
            if (!en[i]) begin
                m_run[i] = 0;
                if (wr) begin
                    m_per[i] = int'(cfg_period); m_high[i] = int'(cfg_high); m_ph[i] = int'(cfg_phase);
                end else if (m_pend[i]) begin
                    m_per[i] = s_per[i]; m_high[i] = s_high[i]; m_ph[i] = s_ph[i];
                end
                m_pend[i] = 0;
            end else if (!m_run[i]) begin
                m_tph[i] = m_ph[i];
                if (wr) begin
                    m_per[i] = int'(cfg_period); m_high[i] = int'(cfg_high); m_ph[i] = int'(cfg_phase);
                end
                m_run[i] = 1; m_t[i] = 0; m_pos[i] = 0;
            end else begin
                if (m_t[i] < m_tph[i]) begin
                    m_t[i]++;
                    m_pos[i] = 0;
                end else begin
                    m_pos[i]++;
                    if (m_pos[i] >= p_of(m_per[i])) begin
                        m_pos[i] = 0;
                        if (m_pend[i]) begin
                            m_per[i] = s_per[i]; m_high[i] = s_high[i]; m_ph[i] = s_ph[i];
                            m_pend[i] = 0;
                        end
                    end
                end
                if (wr) begin
                    s_per[i] = int'(cfg_period); s_high[i] = int'(cfg_high); s_ph[i] = int'(cfg_phase);
                    m_pend[i] = 1;
                end
            end
            m_out[i]  = m_run[i] && (m_t[i] >= m_tph[i]) && (m_pos[i] < h_of(m_per[i], m_high[i]));
            m_rise[i] = m_out[i] && !old;
        end
    endtask

    // One clock: check ready, advance DUT and model, check outputs.
    task automatic step();
        bit exp_rdy;
        #1;
        exp_rdy    = rst || !m_pend[cfg_ch];
        last_ready = cfg_ready;
        chk("cfg_ready", int'(cfg_ready), int'(exp_rdy));
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("clk_out[%0d]", i), int'(clk_out[i]), int'(m_out[i]));
`ifdef PWM_CLKGEN_STROBE_EN
            chk($sformatf("rise_strb[%0d]", i), int'(rise_strb[i]), int'(m_rise[i]));
`endif
        end
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Single-cycle write; the caller knows the target is ready.
    task automatic write1(int ch, int p, int h, int ph);
        cfg_valid = 1'b1; cfg_ch = 2'(ch);
        cfg_period = CW'(p); cfg_high = CW'(h); cfg_phase = CW'(ph);
        step();
        cfg_valid = 1'b0;
        $display("[TB] write ch%0d period=%0d high=%0d phase=%0d ready=%0d", ch, p, h, ph, last_ready);
    endtask

    typedef struct {
        int per;
        int high;
        int ph;
        int lat;   // index of first high sample after the enable edge, -1 = never
        int ones;  // high samples among the first 20 after the enable edge
    } vec_t;

    vec_t vecs[8];

    initial begin
        int first, ones, stall, waited;

        vecs[0] = '{2, 1, 0, 0, 10};
        vecs[1] = '{10, 3, 4, 4, 6};
        vecs[2] = '{10, 0, 0, -1, 0};
        vecs[3] = '{10, 12, 0, 0, 20};
        vecs[4] = '{0, 1, 2, 2, 18};
        vecs[5] = '{5, 2, 1, 1, 8};
        vecs[6] = '{1, 0, 3, -1, 0};
        vecs[7] = '{3, 3, 0, 0, 20};

        rst = 1'b1; en = '1; cfg_valid = 1'b1; cfg_ch = 0;
        cfg_period = 16'd9; cfg_high = 16'd9; cfg_phase = 16'd9;
        steps(2);
        cfg_valid = 1'b0; en = '0;
        for (int c = 0; c < NCH; c++) begin
            cfg_ch = 2'(c);
            #1 chk("reset_ready", int'(cfg_ready), 1);
        end
        chk("reset_clk_out", int'(clk_out), 0);
        rst = 1'b0;
        steps(1);

        // Defaults: P=2, H=1 toggling from the enable edge.
        en[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("default_toggle", int'(clk_out[0]), (j % 2 == 0) ? 1 : 0);
        end
        $display("[TB] default toggle on ch0 checked");
        en[0] = 1'b0;
        step();

        // Table vectors on idle channel 2.
        foreach (vecs[v]) begin
            write1(2, vecs[v].per, vecs[v].high, vecs[v].ph);
            en[2] = 1'b1;
            first = -1; ones = 0;
            for (int j = 0; j < 20; j++) begin
                step();
                if (clk_out[2] && first < 0) first = j;
                ones += int'(clk_out[2]);
            end
            chk($sformatf("vec%0d_latency", v), first, vecs[v].lat);
            chk($sformatf("vec%0d_ones", v), ones, vecs[v].ones);
            $display("[TB] vec%0d P=%0d H=%0d ph=%0d first=%0d ones=%0d", v,
                     vecs[v].per, vecs[v].high, vecs[v].ph, first, ones);
            en[2] = 1'b0;
            step();
        end

        // Pending update on a running channel, and a stalled second write.
        write1(1, 10, 3, 4);
        en[1] = 1'b1;
        steps(14);
        write1(1, 6, 2, 0);
        cfg_ch = 2'd1;
        #1 chk("pending_blocks_ready", int'(cfg_ready), 0);
        cfg_valid = 1'b1; cfg_period = 16'd8; cfg_high = 16'd5; cfg_phase = 16'd0;
        stall = 0; waited = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (last_ready) begin waited = 1; break; end
            stall++;
        end
        cfg_valid = 1'b0;
        chk("second_write_accepted", waited, 1);
        chk("second_write_stalled", int'(stall > 0), 1);
        $display("[TB] second write ch1 8/5 stalled %0d cycles", stall);
        steps(40);

        // Disable mid-high with a write pending; re-enable uses the new values.
        waited = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (clk_out[1]) begin waited = 1; break; end
        end
        chk("wait_high_ch1", waited, 1);
        write1(1, 3, 1, 2);
        en[1] = 1'b0;
        step();
        chk("disable_low", int'(clk_out[1]), 0);
        cfg_ch = 2'd1;
        #1 chk("disable_clears_pending", int'(cfg_ready), 1);
        en[1] = 1'b1;
        first = -1;
        for (int j = 0; j < 12; j++) begin
            step();
            if (clk_out[1] && first < 0) first = j;
        end
        chk("reenable_latency", first, 2);
        $display("[TB] disable/re-enable ch1 first high at %0d", first);

        // Reset mid-run overrides en and cfg_valid.
        en = '1;
        steps(5);
        rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0;
        step();
        chk("midrun_reset_out", int'(clk_out), 0);
        #1 chk("midrun_reset_ready", int'(cfg_ready), 1);
        rst = 1'b0; cfg_valid = 1'b0; en = '0;
        step();
        $display("[TB] mid-run reset checked");

`ifdef PWM_CLKGEN_STROBE_EN
        write1(3, 5, 2, 0);
        en[3] = 1'b1;
        ones = 0;
        for (int j = 0; j < 25; j++) begin
            step();
            ones += int'(rise_strb[3]);
        end
        chk("strobe_count", ones, 5);
        $display("[TB] strobe ch3 P=5 H=2 pulses=%0d", ones);
        en[3] = 1'b0;
        step();
`endif

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, NCH - 1));
            cfg_period = CW'($urandom_range(0, 7));
            cfg_high   = CW'($urandom_range(0, 8));
            cfg_phase  = CW'($urandom_range(0, 3));
            step();
            if (cfg_valid && last_ready && !rst)
                $display("[TB] rand write ch%0d period=%0d high=%0d phase=%0d",
                         cfg_ch, cfg_period, cfg_high, cfg_phase);
        end
        rst = 1'b0; cfg_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
